// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side hazard inputs, forwarding/stall controls, MD status.
// stall_count width follows `WORD_SIZE (defaults to 32 when the core does not define it).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface hazard_ctrl_if;
  logic [4:0]             rs_d, rt_d, rs_e, rt_e;
  logic [4:0]             write_reg_e, write_reg_m, write_reg_w;
  logic                   reg_write_e, reg_write_m, reg_write_w;
  logic                   mem_to_reg_e, mem_to_reg_m;
  logic                   branch_d, jr_d;
  logic                   md_start_e, md_is_div_e, hilo_use_d;
  logic                   forward_a_d, forward_b_d;
  logic [1:0]             forward_a_e, forward_b_e;
  logic                   stall_f, stall_d, flush_e;
  logic                   md_busy, md_done;
  logic [`WORD_SIZE-1:0]  stall_count;

  // Hazard controller side
  modport master (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, jr_d, md_start_e, md_is_div_e, hilo_use_d,
    output forward_a_d, forward_b_d, forward_a_e, forward_b_e,
           stall_f, stall_d, flush_e, md_busy, md_done, stall_count
  );

  // Pipeline side
  modport slave (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, jr_d, md_start_e, md_is_div_e, hilo_use_d,
    input  forward_a_d, forward_b_d, forward_a_e, forward_b_e,
           stall_f, stall_d, flush_e, md_busy, md_done, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load/branch/HI-LO stalls, MD busy tracker.
// Optional HAZARD_STATS_EN adds a saturating stall-cycle counter on stall_count.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.master hz
);
  localparam int unsigned CW = 6;
  localparam int unsigned SW = `WORD_SIZE;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_q, done_nxt;
  logic          lw_stall, br_stall, md_stall, stall;

  // Register $0 never matches; a match also needs the producer's enable.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hit(src, hz.write_reg_m, hz.reg_write_m))      return 2'b10;
    else if (hit(src, hz.write_reg_w, hz.reg_write_w)) return 2'b01;
    else                                                return 2'b00;
  endfunction

  // Forwarding selects and stall/flush controls
  always_comb begin
    hz.forward_a_e = fwd_sel(hz.rs_e);
    hz.forward_b_e = fwd_sel(hz.rt_e);
    hz.forward_a_d = hit(hz.rs_d, hz.write_reg_m, hz.reg_write_m);
    hz.forward_b_d = hit(hz.rt_d, hz.write_reg_m, hz.reg_write_m);

    lw_stall = hit(hz.rs_d, hz.write_reg_e, hz.mem_to_reg_e) ||
               hit(hz.rt_d, hz.write_reg_e, hz.mem_to_reg_e);
    br_stall = (hz.branch_d &&
                (hit(hz.rs_d, hz.write_reg_e, hz.reg_write_e)  ||
                 hit(hz.rt_d, hz.write_reg_e, hz.reg_write_e)  ||
                 hit(hz.rs_d, hz.write_reg_m, hz.mem_to_reg_m) ||
                 hit(hz.rt_d, hz.write_reg_m, hz.mem_to_reg_m))) ||
               (hz.jr_d &&
                (hit(hz.rs_d, hz.write_reg_e, hz.reg_write_e)  ||
                 hit(hz.rs_d, hz.write_reg_m, hz.mem_to_reg_m)));
    md_stall = hz.hilo_use_d && ((state == BUSY) || hz.md_start_e);
    stall    = lw_stall || br_stall || md_stall;

    hz.stall_f = stall;
    hz.stall_d = stall;
    hz.flush_e = stall;
  end

  // MD tracker: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  // MD tracker: next state; a start while BUSY is dropped
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (hz.md_start_e) begin
          state_nxt = BUSY;
          cnt_nxt   = hz.md_is_div_e ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MD tracker: outputs straight from flops
  always_comb begin
    hz.md_busy = (state == BUSY);
    hz.md_done = done_q;
  end

`ifdef HAZARD_STATS_EN
  logic [SW-1:0] stall_cnt_q;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {SW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + SW'(1);
    end
  end

  assign hz.stall_count = stall_cnt_q;
`else
  assign hz.stall_count = SW'(0);
`endif

endmodule
